// File: rtl/input_debouncer_if.sv
// rtl/input_debouncer_if.sv - channel bundle between raw inputs and debounced outputs
//
// Purpose : groups the per-channel raw inputs and the debounced results of
//           input_debouncer so that they travel as one port.
// Signals : raw_in    [N] bouncy asynchronous channel inputs
//           level_out [N] debounced stable level
//           rise_out  [N] one-cycle pulse on accepted 0->1
//           fall_out  [N] one-cycle pulse on accepted 1->0
//           held_out  [N] long-press flag
// Modports: master drives raw_in and observes the results; slave is the debouncer.

interface input_debouncer_if #(
  parameter int N = 13
) ();

  logic [N-1:0] raw_in;
  logic [N-1:0] level_out;
  logic [N-1:0] rise_out;
  logic [N-1:0] fall_out;
  logic [N-1:0] held_out;

  modport master (
    output raw_in,
    input  level_out,
    input  rise_out,
    input  fall_out,
    input  held_out
  );

  modport slave (
    input  raw_in,
    output level_out,
    output rise_out,
    output fall_out,
    output held_out
  );

endinterface

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - N-channel synchronising debouncer with edge pulses and long-press detect
//
// Purpose : each channel is synchronised through two flops, then a new level is
//           accepted only after it has been seen for DEBOUNCE_CYCLES consecutive
//           cycles. Accepted transitions produce registered rise/fall pulses, and a
//           level held high for HOLD_CYCLES raises a sticky long-press flag.
// Ports   : clk   - single clock, all state updates on its rising edge
//           rst_n - synchronous active-low reset
//           io    - input_debouncer_if.slave (raw_in, level_out, rise_out,
//                   fall_out, held_out, each N bits wide)

module input_debouncer #(
  parameter int unsigned N               = 13,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned HOLD_CYCLES     = 50000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input_debouncer_if.slave   io
);

  localparam int unsigned     CW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0]     HOLD_LAST = 32'(HOLD_CYCLES - 1);

  // Synchroniser: sync_meta may be metastable and is never used directly.
  logic [N-1:0]  sync_meta;
  logic [N-1:0]  sync;

  // Registered state.
  logic [CW-1:0] db_cnt   [N];
  logic [31:0]   hold_cnt [N];
  logic [N-1:0]  level;
  logic [N-1:0]  rise;
  logic [N-1:0]  fall;
  logic [N-1:0]  held;

  // Next-state values.
  logic [CW-1:0] db_cnt_nxt   [N];
  logic [31:0]   hold_cnt_nxt [N];
  logic [N-1:0]  level_nxt;
  logic [N-1:0]  rise_nxt;
  logic [N-1:0]  fall_nxt;
  logic [N-1:0]  held_nxt;

  always_comb begin
    level_nxt = level;
    rise_nxt  = '0;
    fall_nxt  = '0;
    held_nxt  = held;
    for (int i = 0; i < int'(N); i++) begin
      db_cnt_nxt[i]   = '0;
      hold_cnt_nxt[i] = '0;

      // Debounce: count only while the synchronised input disagrees with the
      // accepted level. Any agreeing cycle leaves the count at zero, so a
      // glitch restarts the whole window instead of pausing it.
      if (sync[i] != level[i]) begin
        if (db_cnt[i] == DB_LAST) begin
          level_nxt[i] = sync[i];
          rise_nxt[i]  = sync[i];
          fall_nxt[i]  = ~sync[i];
        end else begin
          db_cnt_nxt[i] = db_cnt[i] + CW'(1);
        end
      end

      // Long press: count high cycles until the flag sets, then park at zero.
      // The flag itself is sticky until the level falls, so it never re-pulses.
      if (level[i] && !held[i]) begin
        if (hold_cnt[i] == HOLD_LAST) begin
          held_nxt[i] = 1'b1;
        end else begin
          hold_cnt_nxt[i] = hold_cnt[i] + 32'd1;
        end
      end

      // A falling acceptance wins over a hold flag setting on the same edge,
      // so held never shows 1 alongside a low level.
      if (!level_nxt[i]) begin
        held_nxt[i]     = 1'b0;
        hold_cnt_nxt[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync      <= '0;
      level     <= '0;
      rise      <= '0;
      fall      <= '0;
      held      <= '0;
      for (int i = 0; i < int'(N); i++) begin
        db_cnt[i]   <= '0;
        hold_cnt[i] <= '0;
      end
    end else begin
      sync_meta <= io.raw_in;
      sync      <= sync_meta;
      level     <= level_nxt;
      rise      <= rise_nxt;
      fall      <= fall_nxt;
      held      <= held_nxt;
      for (int i = 0; i < int'(N); i++) begin
        db_cnt[i]   <= db_cnt_nxt[i];
        hold_cnt[i] <= hold_cnt_nxt[i];
      end
    end
  end

  assign io.level_out = level;
  assign io.rise_out  = rise;
  assign io.fall_out  = fall;
  assign io.held_out  = held;

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - scoreboard bench for input_debouncer with a window-based reference model

module tb_input_debouncer;

  localparam int N    = 4;
  localparam int D    = 4;
  localparam int H    = 10;
  localparam int MAXE = 4000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  input_debouncer_if #(.N(N)) dif ();

  input_debouncer #(
    .N              (N),
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (dif)
  );

  typedef struct {
    int           cyc;
    logic [N-1:0] lv;
    logic [N-1:0] ri;
    logic [N-1:0] fa;
    logic [N-1:0] he;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state: raw samples indexed by edge number, plus for each
  // channel the accepted level, the edge it last changed (or was reset) and the
  // edge it last rose.
  logic [N-1:0] hist [MAXE];
  int           edge_no = 0;
  logic         m_level     [N];
  int           last_change [N];
  int           rise_edge   [N];

  // Value the two-flop synchroniser presents at edge e: the raw sample two edges back.
  function automatic logic sync_bit(int e, int i);
    logic [N-1:0] v;
    v = (e >= 2) ? hist[e-2] : '0;
    return v[i];
  endfunction

  task automatic model_edge(input logic [N-1:0] raw, input logic rst);
    exp_t x;
    bit   acc;
    int   e;
    e     = edge_no;
    x.cyc = e;
    x.lv  = '0;
    x.ri  = '0;
    x.fa  = '0;
    x.he  = '0;
    hist[e] = raw;
    if (!rst) begin
      // Reset clears both synchroniser stages: the two most recent samples read as 0.
      hist[e] = '0;
      if (e > 0) hist[e-1] = '0;
      for (int i = 0; i < N; i++) begin
        m_level[i]     = 1'b0;
        last_change[i] = e;
        rise_edge[i]   = e;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        // Accept only when the last D synchronised samples all disagree with
        // the level and all lie after the previous change/reset.
        acc = (e - last_change[i] >= D);
        for (int j = 0; j < D; j++)
          if (sync_bit(e - j, i) == m_level[i]) acc = 1'b0;
        if (acc) begin
          m_level[i]     = ~m_level[i];
          last_change[i] = e;
          if (m_level[i]) begin
            x.ri[i]      = 1'b1;
            rise_edge[i] = e;
          end else begin
            x.fa[i] = 1'b1;
          end
        end
        x.lv[i] = m_level[i];
        x.he[i] = m_level[i] && (e - rise_edge[i] >= H);
      end
    end
    sb.push_back(x);
    edge_no++;
  endtask

  task automatic step(input logic [N-1:0] raw, input logic rst);
    dif.raw_in = raw;
    rst_n      = rst;
    @(posedge clk);
    model_edge(raw, rst);
    #2;
  endtask

  task automatic cmp(input string name, input int cyc, input logic [N-1:0] got, input logic [N-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s edge=%0d got=%b required=%b", name, cyc, got, want);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare it with
  // the oldest expectation.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        cmp("level_out", x.cyc, dif.level_out, x.lv);
        cmp("rise_out",  x.cyc, dif.rise_out,  x.ri);
        cmp("fall_out",  x.cyc, dif.fall_out,  x.fa);
        cmp("held_out",  x.cyc, dif.held_out,  x.he);
      end
    end
  end

  initial begin
    logic [N-1:0] tgt;
    logic [N-1:0] r;
    dif.raw_in = '0;

    repeat (3) step('0, 1'b0);

    // Single channel accepted, held into long-press, then released.
    repeat (22) step(4'b0001, 1'b1);
    repeat (8)  step(4'b0000, 1'b1);

    // Toggling every two cycles never survives the window.
    for (int k = 0; k < 20; k++)
      step(((k / 2) % 2 == 0) ? 4'b0001 : 4'b0000, 1'b1);
    repeat (8) step('0, 1'b1);

    // All channels together.
    repeat (10) step(4'b1111, 1'b1);
    repeat (10) step('0, 1'b1);

    // Reset while channel 0 is mid-count, raw held throughout.
    repeat (4)  step(4'b0001, 1'b1);
    step(4'b0001, 1'b0);
    repeat (10) step(4'b0001, 1'b1);
    repeat (8)  step('0, 1'b1);

    // Random bouncy traffic with occasional resets.
    tgt = '0;
    for (int k = 0; k < 2500; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 39) == 0) tgt[i] = ~tgt[i];
        r[i] = ($urandom_range(0, 5) == 0) ? ~tgt[i] : tgt[i];
      end
      step(r, ($urandom_range(0, 599) != 0));
    end

    step('0, 1'b1);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain left=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 The block SHALL have parameter N, default 13, giving the number of independent input channels (for example 5 buttons plus 8 switches).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 100000, giving the consecutive-cycle stability count needed to accept a new level; legal range 1 to 2^24.
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 50000000, giving the cycles a channel must stay stable-high before long-press is flagged; legal range 1 to 2^32-1.
REQ-004 Port clk, input, width 1: the single clock; all state SHALL update on its rising edge only.
REQ-005 Port rst_n, input, width 1: reset, synchronous and active-low.
REQ-006 Port raw_in, input, width N: asynchronous, bouncy channel inputs.
REQ-007 Port level_out, output, width N: debounced stable level per channel.
REQ-008 Port rise_out, output, width N: one-cycle pulse on each accepted 0->1 transition.
REQ-009 Port fall_out, output, width N: one-cycle pulse on each accepted 1->0 transition.
REQ-010 Port held_out, output, width N: long-press flag per channel.

Function
REQ-011 Each channel SHALL pass raw_in[i] through a 2-flop synchroniser; only the second flop output, sync[i], is used downstream.
REQ-012 Each channel SHALL have its own debounce counter, width ceil(log2(DEBOUNCE_CYCLES+1)); channels SHALL NOT share or influence each other's counters.
REQ-013 Per edge, when sync[i]==level_out[i], the debounce counter[i] SHALL be cleared to 0.
REQ-014 Per edge, when sync[i]!=level_out[i] and counter[i]<DEBOUNCE_CYCLES-1, counter[i] SHALL increment by 1.
REQ-015 Per edge, when sync[i]!=level_out[i] and counter[i]==DEBOUNCE_CYCLES-1, level_out[i] SHALL take sync[i] and counter[i] SHALL clear to 0.
REQ-016 Any single-cycle return of sync[i] to level_out[i] SHALL restart the count from 0; partial counts SHALL NOT accumulate across glitches.
REQ-017 Latency: if raw_in[i] changes before edge k and then holds, level_out[i] SHALL change after edge k+DEBOUNCE_CYCLES+1, and not earlier.
REQ-018 rise_out[i] SHALL be 1 for exactly the one cycle following the edge on which level_out[i] goes 0->1; fall_out[i] SHALL behave the same for 1->0.
REQ-019 rise_out and fall_out SHALL be registered outputs, never both 1 on the same channel in the same cycle, and 0 at all other times.
REQ-020 Each channel SHALL have a hold counter, width 32, that is cleared whenever level_out[i]==0 or held_out[i]==1.
REQ-021 When level_out[i]==1 and held_out[i]==0, the hold counter SHALL increment; held_out[i] SHALL set on the edge where the hold counter equals HOLD_CYCLES-1.
REQ-022 held_out[i] SHALL clear on the same edge that level_out[i] goes 1->0, and SHALL never be 1 while level_out[i]==0.
REQ-023 The hold counter SHALL saturate: once held_out[i] is set, it SHALL NOT wrap and SHALL NOT re-pulse.
REQ-024 Simultaneous transitions on several channels SHALL each produce their own rise/fall pulse in the same cycle, with no arbitration.
REQ-025 A raw_in change that does not persist for DEBOUNCE_CYCLES synchronised cycles SHALL produce no change on any output.

Reset
REQ-026 While rst_n==0 at a clk rising edge, synchroniser flops, debounce counters, hold counters, level_out, rise_out, fall_out and held_out SHALL all become 0.
REQ-027 Reset asserted mid-count SHALL discard the partial count.
REQ-028 After reset deasserts, a channel whose raw_in is already 1 SHALL follow the normal REQ-017 latency and then emit one rise_out pulse.
REQ-029 rst_n SHALL be sampled only on clk; rst_n SHALL have no asynchronous effect.

Verification (N=4, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10)
REQ-030 raw_in=4'b0001 held from edge 0 -> level_out[0]=1 after edge 5, rise_out=4'b0001 for exactly that one cycle, and no earlier change.
REQ-031 raw_in[0] toggling 1,0,1,0 every 2 cycles for 20 cycles -> level_out, rise_out and fall_out stay 0 throughout.
REQ-032 Channel 0 held at 1 after acceptance -> held_out[0]=1 exactly 10 edges after level_out[0] rose; releasing raw_in[0] -> fall_out[0] pulse and held_out[0]=0 on the same edge.
REQ-033 raw_in=4'b1111 applied in one cycle -> rise_out=4'b1111 in a single cycle, and level_out=4'hF thereafter.
REQ-034 rst_n=0 for 1 cycle while counter[0]==2 -> all outputs 0; with raw_in held, level_out[0] rises 5 edges after the first edge with rst_n=1.
